// File: rtl/rd53_lane_distributor.sv
// Stripes input frames round-robin over the active lanes and emits aligned rows, idling when a row is incomplete.
// Optional idle-row statistics counter is built only when LANE_DIST_STATS_EN is defined.
module rd53_lane_distributor #(
  parameter int                 NUM_LANES  = 4,
  parameter int                 FRAME_W    = 64,
  parameter int                 FIFO_DEPTH = 8,
  parameter logic [FRAME_W-1:0] IDLE_FRAME = 64'h7800_0000_0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   lane_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FRAME_W-1:0]           in_frame,
  input  logic                         in_service,
  input  logic [NUM_LANES-1:0]         lane_next,
  output logic [NUM_LANES*FRAME_W-1:0] lane_data,
  output logic [2*NUM_LANES-1:0]       lane_sync,
  output logic [15:0]                  idle_cnt
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int AW = $clog2(NUM_LANES) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = FRAME_W + 1;

  logic [EW-1:0]                mem_q [NUM_LANES][FIFO_DEPTH];
  logic [EW-1:0]                mem_d [NUM_LANES][FIFO_DEPTH];
  logic [PW-1:0]                rd_ptr_q [NUM_LANES];
  logic [PW-1:0]                rd_ptr_d [NUM_LANES];
  logic [PW-1:0]                wr_ptr_q [NUM_LANES];
  logic [PW-1:0]                wr_ptr_d [NUM_LANES];
  logic [CW-1:0]                cnt_q [NUM_LANES];
  logic [CW-1:0]                cnt_d [NUM_LANES];
  logic [LW-1:0]                wr_lane_q, wr_lane_d;
  logic [AW-1:0]                act_q, act_d, act_req;
  logic [NUM_LANES*FRAME_W-1:0] lane_data_q, lane_data_d;
  logic [2*NUM_LANES-1:0]       lane_sync_q, lane_sync_d;
  logic                         data_next, row_avail, pop, wr_en, all_empty;
  logic                         wr_i, rd_i;

  // Requested lane count, limited to the physical lanes present.
  always_comb begin
    act_req = AW'(NUM_LANES);
    if ((1 << lane_mode) < NUM_LANES) act_req = AW'(1 << lane_mode);
  end

  always_comb begin
    data_next   = |lane_next;
    in_ready    = reset && (cnt_q[wr_lane_q] != CW'(FIFO_DEPTH));
    wr_en       = in_valid && in_ready;
    row_avail   = 1'b1;
    all_empty   = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (cnt_q[i] != '0) all_empty = 1'b0;
      if (i < int'(act_q) && cnt_q[i] == '0) row_avail = 1'b0;
    end
    pop         = data_next && row_avail;
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    lane_data_d = lane_data_q;
    lane_sync_d = lane_sync_q;
    wr_lane_d   = wr_lane_q;
    act_d       = act_q;
    wr_i        = 1'b0;
    rd_i        = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      wr_i = wr_en && (wr_lane_q == LW'(i));
      rd_i = pop && (i < int'(act_q));
      if (wr_i) begin
        mem_d[i][wr_ptr_q[i]] = {in_service, in_frame};
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (rd_i) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      cnt_d[i] = cnt_q[i] + CW'(wr_i) - CW'(rd_i);
      if (data_next) begin
        if (rd_i) begin
          lane_data_d[i*FRAME_W +: FRAME_W] = mem_q[i][rd_ptr_q[i]][FRAME_W-1:0];
          lane_sync_d[2*i +: 2] = mem_q[i][rd_ptr_q[i]][FRAME_W] ? 2'b10 : 2'b01;
        end else begin
          lane_data_d[i*FRAME_W +: FRAME_W] = IDLE_FRAME;
          lane_sync_d[2*i +: 2]             = 2'b10;
        end
      end
    end
    if (wr_en) wr_lane_d = (wr_lane_q == LW'(act_q - 1'b1)) ? '0 : wr_lane_q + 1'b1;
    // Only switch striping width when nothing is in flight, so no frame is reordered.
    if (all_empty && wr_lane_q == '0 && !wr_en) act_d = act_req;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      wr_lane_q   <= '0;
      act_q       <= act_req;
      lane_data_q <= {NUM_LANES{IDLE_FRAME}};
      lane_sync_q <= {NUM_LANES{2'b10}};
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      wr_lane_q   <= wr_lane_d;
      act_q       <= act_d;
      lane_data_q <= lane_data_d;
      lane_sync_q <= lane_sync_d;
    end
  end

  assign lane_data = lane_data_q;
  assign lane_sync = lane_sync_q;

`ifdef LANE_DIST_STATS_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (data_next && !row_avail && idle_cnt_q != 16'hFFFF) idle_cnt_d = idle_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end

  assign idle_cnt = idle_cnt_q;
`else
  assign idle_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_rd53_lane_distributor.sv
// Bench for rd53_lane_distributor: directed vector table, hand sequences and random traffic against a queue model.
module tb_rd53_lane_distributor;
  localparam int NL = 4;
  localparam int FW = 64;
  localparam int D  = 8;
  localparam logic [63:0] IDLE = 64'h7800_0000_0000_0000;
`ifdef LANE_DIST_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       lane_mode = 2'd2;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [FW-1:0]    in_frame = '0;
  logic             in_service = 1'b0;
  logic [NL-1:0]    lane_next = '0;
  logic [NL*FW-1:0] lane_data;
  logic [2*NL-1:0]  lane_sync;
  logic [15:0]      idle_cnt;

  rd53_lane_distributor #(.NUM_LANES(NL), .FRAME_W(FW), .FIFO_DEPTH(D), .IDLE_FRAME(IDLE)) dut (
    .clk(clk), .reset(reset), .lane_mode(lane_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_frame(in_frame), .in_service(in_service), .lane_next(lane_next),
    .lane_data(lane_data), .lane_sync(lane_sync), .idle_cnt(idle_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: one queue per lane, the stripe position and the active lane count.
  logic [64:0] mq [NL][$];
  int          m_wr = 0;
  int          m_act = NL;
  logic [63:0] m_data [NL];
  logic [1:0]  m_sync [NL];
  int          m_idle = 0;

  function automatic int clamp(input logic [1:0] m);
    int a;
    a = 1 << m;
    return (a > NL) ? NL : a;
  endfunction

  function automatic logic [255:0] row4(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] c, input logic [63:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit rst_n, input logic [1:0] mode, input bit v, input logic [63:0] f,
                     input bit s, input logic [NL-1:0] nx, output bit rdy_s);
    bit exp_rdy, acc, row, all_empty, mode_ok;
    logic [64:0] e;
    logic [NL*FW-1:0] ed;
    logic [2*NL-1:0] es;
    reset = rst_n; lane_mode = mode; in_valid = v; in_frame = f; in_service = s; lane_next = nx;
    #1;
    exp_rdy = rst_n && (mq[m_wr].size() < D);
    rdy_s = in_ready;
    chk("in_ready", 256'(in_ready), 256'(exp_rdy));
    acc = v && exp_rdy;
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) begin
        mq[i].delete();
        m_data[i] = IDLE;
        m_sync[i] = 2'b10;
      end
      m_wr = 0; m_act = clamp(mode); m_idle = 0;
    end else begin
      row = 1'b1; all_empty = 1'b1;
      for (int i = 0; i < NL; i++) begin
        if (mq[i].size() != 0) all_empty = 1'b0;
        if (i < m_act && mq[i].size() == 0) row = 1'b0;
      end
      mode_ok = all_empty && (m_wr == 0) && !acc;
      if (|nx) begin
        for (int i = 0; i < NL; i++) begin
          if (row && i < m_act) begin
            e = mq[i].pop_front();
            m_data[i] = e[63:0];
            m_sync[i] = e[64] ? 2'b10 : 2'b01;
          end else begin
            m_data[i] = IDLE;
            m_sync[i] = 2'b10;
          end
        end
        if (!row && STATS && m_idle < 65535) m_idle++;
      end
      if (acc) begin
        mq[m_wr].push_back({s, f});
        m_wr = (m_wr + 1) % m_act;
      end
      if (mode_ok) m_act = clamp(mode);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) begin
      ed[i*FW +: FW] = m_data[i];
      es[2*i +: 2]   = m_sync[i];
    end
    chk("lane_data", 256'(lane_data), 256'(ed));
    chk("lane_sync", 256'(lane_sync), 256'(es));
    chk("idle_cnt", 256'(idle_cnt), 256'(m_idle));
  endtask

  typedef struct {
    bit           rst_n;
    logic [1:0]   mode;
    bit           v;
    logic [63:0]  f;
    logic [NL-1:0] nx;
    bit           e_rdy;
    logic [255:0] e_data;
    logic [7:0]   e_sync;
    logic [15:0]  e_idle;
  } vec_t;

  vec_t tbl [15];

  initial begin
    bit r;
    logic [255:0] all_idle;
    logic [15:0]  s3;
    logic [1:0]   cur_mode;
    int           nx_pct;
    all_idle = row4(IDLE, IDLE, IDLE, IDLE);
    s3 = STATS ? 16'd3 : 16'd0;

    // Reset, three idle pulses, then 8 frames striped over 4 lanes and popped as two rows.
    tbl[0] = '{1'b0, 2'd2, 1'b0, 64'h0, 4'b0000, 1'b0, all_idle, 8'hAA, 16'd0};
    tbl[1] = '{1'b0, 2'd2, 1'b0, 64'h0, 4'b0000, 1'b0, all_idle, 8'hAA, 16'd0};
    tbl[2] = '{1'b1, 2'd2, 1'b0, 64'h0, 4'b0001, 1'b1, all_idle, 8'hAA, STATS ? 16'd1 : 16'd0};
    tbl[3] = '{1'b1, 2'd2, 1'b0, 64'h0, 4'b1000, 1'b1, all_idle, 8'hAA, STATS ? 16'd2 : 16'd0};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 64'h0, 4'b0110, 1'b1, all_idle, 8'hAA, s3};
    for (int k = 1; k <= 8; k++)
      tbl[4 + k] = '{1'b1, 2'd2, 1'b1, 64'(k), 4'b0000, 1'b1, all_idle, 8'hAA, s3};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 64'h0, 4'b0100, 1'b1, row4(64'h1, 64'h2, 64'h3, 64'h4), 8'h55, s3};
    tbl[14] = '{1'b1, 2'd2, 1'b0, 64'h0, 4'b0001, 1'b1, row4(64'h5, 64'h6, 64'h7, 64'h8), 8'h55, s3};

    for (int k = 0; k < 15; k++) begin
      cyc(tbl[k].rst_n, tbl[k].mode, tbl[k].v, tbl[k].f, 1'b0, tbl[k].nx, r);
      chk($sformatf("tbl%0d_rdy", k), 256'(r), 256'(tbl[k].e_rdy));
      chk($sformatf("tbl%0d_data", k), 256'(lane_data), tbl[k].e_data);
      chk($sformatf("tbl%0d_sync", k), 256'(lane_sync), 256'(tbl[k].e_sync));
      chk($sformatf("tbl%0d_idle", k), 256'(idle_cnt), 256'(tbl[k].e_idle));
    end

    // Two-lane mode: A,B form a row, C waits in FIFO0 for its partner.
    cyc(1, 2'd1, 0, 64'h0, 0, 4'b0000, r);
    cyc(1, 2'd1, 1, 64'hA, 0, 4'b0000, r);
    cyc(1, 2'd1, 1, 64'hB, 1, 4'b0000, r);
    cyc(1, 2'd1, 1, 64'hC, 0, 4'b0000, r);
    cyc(1, 2'd1, 0, 64'h0, 0, 4'b0001, r);
    chk("m1_lane0", 256'(lane_data[63:0]), 256'(64'hA));
    chk("m1_lane1", 256'(lane_data[127:64]), 256'(64'hB));
    chk("m1_lane2_idle", 256'(lane_data[191:128]), 256'(IDLE));
    chk("m1_sync", 256'(lane_sync), 256'(8'b1010_1001));
    cyc(1, 2'd1, 0, 64'h0, 0, 4'b0001, r);
    chk("m1_row2_idle", 256'(lane_data), all_idle);
    cyc(1, 2'd1, 1, 64'hD, 0, 4'b0000, r);
    cyc(1, 2'd1, 0, 64'h0, 0, 4'b0001, r);
    chk("m1_cd", 256'(lane_data[127:0]), 256'({64'hD, 64'hC}));

    // Single lane: fill FIFO0, then a pop alongside a write still stalls on the full count.
    cyc(1, 2'd0, 0, 64'h0, 0, 4'b0000, r);
    for (int k = 0; k < 8; k++) cyc(1, 2'd0, 1, 64'h100 + 64'(k), 0, 4'b0000, r);
    chk("full_rdy", 256'(in_ready), 256'(1'b0));
    cyc(1, 2'd0, 1, 64'h1FF, 0, 4'b0000, r);
    chk("ninth_rdy", 256'(r), 256'(1'b0));
    cyc(1, 2'd0, 1, 64'h1FE, 0, 4'b0010, r);
    chk("pop_write_rdy", 256'(r), 256'(1'b0));
    chk("pop_lane0", 256'(lane_data[63:0]), 256'(64'h100));
    chk("rdy_after_pop", 256'(in_ready), 256'(1'b1));
    for (int k = 0; k < 7; k++) cyc(1, 2'd0, 0, 64'h0, 0, 4'b0001, r);
    chk("drain_last", 256'(lane_data[63:0]), 256'(64'h107));

    // Mode drop from 4 lanes to 1 with frames in flight is deferred until drained.
    cyc(1, 2'd2, 0, 64'h0, 0, 4'b0000, r);
    cyc(1, 2'd2, 1, 64'h21, 1, 4'b0000, r);
    cyc(1, 2'd2, 1, 64'h22, 0, 4'b0000, r);
    cyc(1, 2'd0, 0, 64'h0, 0, 4'b0001, r);
    cyc(1, 2'd0, 0, 64'h0, 0, 4'b0001, r);
    cyc(1, 2'd0, 1, 64'h23, 0, 4'b0000, r);
    cyc(1, 2'd0, 1, 64'h24, 0, 4'b0000, r);
    cyc(1, 2'd0, 0, 64'h0, 0, 4'b0001, r);
    chk("defer_row", 256'(lane_data), row4(64'h21, 64'h22, 64'h23, 64'h24));
    chk("defer_sync", 256'(lane_sync), 256'(8'b0101_0110));
    cyc(1, 2'd0, 0, 64'h0, 0, 4'b0000, r);
    cyc(1, 2'd0, 1, 64'h31, 0, 4'b0000, r);
    cyc(1, 2'd0, 0, 64'h0, 0, 4'b0001, r);
    chk("one_lane_row", 256'(lane_data), row4(64'h31, IDLE, IDLE, IDLE));

    // Reset with 5 buffered frames flushes them.
    cyc(1, 2'd2, 0, 64'h0, 0, 4'b0000, r);
    for (int k = 0; k < 5; k++) cyc(1, 2'd2, 1, 64'h40 + 64'(k), 0, 4'b0000, r);
    cyc(0, 2'd2, 0, 64'h0, 0, 4'b0001, r);
    chk("rst_idle_cnt", 256'(idle_cnt), 256'(16'd0));
    chk("rst_data", 256'(lane_data), all_idle);
    cyc(1, 2'd2, 0, 64'h0, 0, 4'b0001, r);
    cyc(1, 2'd2, 0, 64'h0, 0, 4'b0001, r);
    chk("flushed_rows", 256'(lane_data), all_idle);

    // Random traffic with phases of scarce and plentiful pops.
    cur_mode = 2'd2;
    for (int n = 0; n < 4000; n++) begin
      nx_pct = ((n / 250) % 2 == 0) ? 15 : 70;
      if ($urandom_range(0, 59) == 0) cur_mode = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 799) != 0, cur_mode, $urandom_range(0, 3) != 0,
          {$urandom, $urandom}, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 99) < nx_pct) ? NL'($urandom_range(1, 15)) : NL'(0), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
